// File: rtl/i_next_write_arbiter.sv
// Round-robin arbiter sharing the i_next RAM write port among N_SPU synaptic
// processing units, with a drain handshake that signals when all writes have committed.
module i_next_write_arbiter #(
    parameter int N_SPU  = 4,
    parameter int DATA_W = 17,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      asyn_reset,
    input  logic [N_SPU-1:0]          req_write,
    input  logic [N_SPU*DATA_W-1:0]   req_data,
    input  logic [N_SPU*ADDR_W-1:0]   req_addr,
    output logic [N_SPU-1:0]          ack,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      busy,
    output logic [CNT_W-1:0]          write_count
);

    localparam int PTR_W = (N_SPU > 1) ? $clog2(N_SPU) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [N_SPU-1:0]    ack_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                flush_done_q;
    logic [CNT_W-1:0]    count_q;
    logic [PTR_W-1:0]    rr_q;

    logic [N_SPU-1:0]    eff;
    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic [N_SPU-1:0]    grant_oh;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [PTR_W-1:0]    rr_d;
    logic                do_grant;

    // An SPU is masked in the cycle it sees its ack, before it can drop its request.
    assign eff = req_write & ~ack_q;

    always_comb begin
        logic [PTR_W-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < N_SPU; i++) begin
            idx = PTR_W'((int'(rr_q) + i) % N_SPU);
            if (!grant_vld && eff[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < N_SPU; k++) begin
            if (PTR_W'(k) == grant_idx) begin
                grant_oh[k] = grant_vld;
                sel_addr    = req_addr[k*ADDR_W +: ADDR_W];
                sel_data    = req_data[k*DATA_W +: DATA_W];
            end
        end
        rr_d = (grant_idx == PTR_W'(N_SPU - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    assign do_grant = grant_vld && (state_q != DONE);

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q      <= RUN;
            ack_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            flush_done_q <= 1'b0;
            count_q      <= '0;
            rr_q         <= '0;
        end else begin
            ack_q        <= '0;
            we_q         <= 1'b0;
            flush_done_q <= 1'b0;
            if (do_grant) begin
                ack_q  <= grant_oh;
                we_q   <= 1'b1;
                addr_q <= sel_addr;
                data_q <= sel_data;
                rr_q   <= rr_d;
                if (count_q != '1) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
            case (state_q)
                RUN: begin
                    if (flush_req) begin
                        state_q <= DRAIN;
                    end
                end
                // Empty eff here means the final write was presented last cycle and commits now.
                DRAIN: begin
                    if (!grant_vld) begin
                        state_q      <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    count_q <= '0;
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;
    assign flush_done  = flush_done_q;
    assign write_count = count_q;
    assign busy        = (|req_write) | we_q | (state_q != RUN);

endmodule

// File: tb/tb_i_next_write_arbiter.sv
// Directed bench for i_next_write_arbiter: vector table for arbitration and drain,
// plus hand-written sequences for reset, counter saturation and back-to-back flushes.
module tb_i_next_write_arbiter;

    localparam int N      = 4;
    localparam int DW     = 17;
    localparam int AW     = 8;
    localparam int CW     = 4;

    logic            clk;
    logic            asyn_reset;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_data;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    ack;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            flush_req;
    logic            flush_done;
    logic            busy;
    logic [CW-1:0]   write_count;

    int nChecks = 0;
    int nFails  = 0;

    logic [AW-1:0] addrTab [N];
    logic [DW-1:0] dataTab [N];

    typedef struct {
        logic [N-1:0]  req;
        logic          flush;
        logic [N-1:0]  expAck;
        logic          expWe;
        int            expIdx;
        logic          expFd;
        logic          expBusy;
        logic [CW-1:0] expCnt;
    } vec_t;

    vec_t vecs [16];

    i_next_write_arbiter #(
        .N_SPU (N),
        .DATA_W(DW),
        .ADDR_W(AW),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .req_write  (req_write),
        .req_data   (req_data),
        .req_addr   (req_addr),
        .ack        (ack),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .busy       (busy),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic flush);
        req_write = req;
        flush_req = flush;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [N-1:0] eAck, input logic eWe, input int eIdx,
                            input logic eFd, input logic eBusy, input logic [CW-1:0] eCnt);
        checkOutput({tag, " ack"}, 32'(ack), 32'(eAck));
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(eWe));
        checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(addrTab[eIdx]));
        checkOutput({tag, " mem_data"}, 32'(mem_data), 32'(dataTab[eIdx]));
        checkOutput({tag, " flush_done"}, 32'(flush_done), 32'(eFd));
        checkOutput({tag, " busy"}, 32'(busy), 32'(eBusy));
        checkOutput({tag, " write_count"}, 32'(write_count), 32'(eCnt));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ack"}, 32'(ack), 32'h0);
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'h0);
        checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        checkOutput({tag, " mem_data"}, 32'(mem_data), 32'h0);
        checkOutput({tag, " flush_done"}, 32'(flush_done), 32'h0);
        checkOutput({tag, " write_count"}, 32'(write_count), 32'h0);
    endtask

    initial begin
        addrTab[0] = 8'hA0;  dataTab[0] = 17'h1ABCD;
        addrTab[1] = 8'h11;  dataTab[1] = 17'h00011;
        addrTab[2] = 8'h05;  dataTab[2] = 17'h00900;
        addrTab[3] = 8'hFF;  dataTab[3] = 17'h1FFFF;
        req_data = {dataTab[3], dataTab[2], dataTab[1], dataTab[0]};
        req_addr = {addrTab[3], addrTab[2], addrTab[1], addrTab[0]};

        // req, flush, ack, we, bus index, flush_done, busy, write_count
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 0, 1'b0, 1'b1, 4'd1};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1, 1'b0, 1'b1, 4'd2};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2, 1'b0, 1'b1, 4'd3};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3, 1'b0, 1'b1, 4'd4};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 0, 1'b0, 1'b1, 4'd5};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1, 1'b0, 1'b1, 4'd6};
        vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 1'b0, 1'b1, 4'd7};
        vecs[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 1'b1, 4'd7};
        vecs[8]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 0, 1'b0, 1'b1, 4'd8};
        vecs[9]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1, 1'b0, 1'b1, 4'd9};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b0, 1'b0, 4'd9};
        vecs[11] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0, 1'b0, 1'b1, 4'd10};
        vecs[12] = '{4'b0011, 1'b0, 4'b0010, 1'b1, 1, 1'b0, 1'b1, 4'd11};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b1, 1'b1, 4'd11};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b0, 1'b0, 4'd0};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b0, 1'b0, 4'd0};

        asyn_reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        repeat (2) stepCycle();
        checkResetOutputs("initial reset");
        checkOutput("initial reset busy", 32'(busy), 32'h0);
        asyn_reset = 1'b0;

        // Build up state, then hit reset mid-cycle with all SPUs requesting.
        applyStimulus(4'b1111, 1'b0);
        stepCycle();
        checkOutput("pre-reset grant0 ack", 32'(ack), 32'h1);
        stepCycle();
        checkOutput("pre-reset grant1 ack", 32'(ack), 32'h2);
        checkOutput("pre-reset count", 32'(write_count), 32'h2);
        #2 asyn_reset = 1'b1;
        #1;
        checkResetOutputs("mid-cycle reset");
        checkOutput("mid-cycle reset busy", 32'(busy), 32'h1);
        #1 asyn_reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].req, vecs[i].flush);
            stepCycle();
            checkAll($sformatf("row%0d", i), vecs[i].expAck, vecs[i].expWe, vecs[i].expIdx,
                     vecs[i].expFd, vecs[i].expBusy, vecs[i].expCnt);
        end

        // Saturation: pointer sits at 2 after the table, counter at 0.
        for (int i = 0; i < 17; i++) begin
            int g;
            g = (2 + i) % 4;
            applyStimulus(4'b1111, 1'b0);
            stepCycle();
            checkOutput($sformatf("sat%0d ack", i), 32'(ack), 32'(1 << g));
            checkOutput($sformatf("sat%0d mem_addr", i), 32'(mem_addr), 32'(addrTab[g]));
            checkOutput($sformatf("sat%0d write_count", i), 32'(write_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end

        // Flush held high across DRAIN, DONE and back into RUN.
        applyStimulus(4'b0000, 1'b1);
        stepCycle();
        checkAll("flushA", 4'b0000, 1'b0, 2, 1'b0, 1'b1, 4'd15);
        stepCycle();
        checkAll("flushB", 4'b0000, 1'b0, 2, 1'b1, 1'b1, 4'd15);
        stepCycle();
        checkAll("flushC", 4'b0000, 1'b0, 2, 1'b0, 1'b0, 4'd0);
        stepCycle();
        checkAll("flushD", 4'b0000, 1'b0, 2, 1'b0, 1'b1, 4'd0);
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        checkAll("flushE", 4'b0000, 1'b0, 2, 1'b1, 1'b1, 4'd0);
        stepCycle();
        checkAll("flushF", 4'b0000, 1'b0, 2, 1'b0, 1'b0, 4'd0);

        // Reset while draining with SPU3 pending.
        applyStimulus(4'b0001, 1'b1);
        stepCycle();
        checkAll("drainG", 4'b0001, 1'b1, 0, 1'b0, 1'b1, 4'd1);
        applyStimulus(4'b1000, 1'b0);
        #2 asyn_reset = 1'b1;
        #1;
        checkResetOutputs("drain reset");
        checkOutput("drain reset busy", 32'(busy), 32'h1);
        stepCycle();
        checkOutput("drain reset held flush_done", 32'(flush_done), 32'h0);
        checkOutput("drain reset held ack", 32'(ack), 32'h0);
        asyn_reset = 1'b0;
        stepCycle();
        checkAll("post-reset spu3", 4'b1000, 1'b1, 3, 1'b0, 1'b1, 4'd1);
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        checkAll("post-reset idle", 4'b0000, 1'b0, 3, 1'b0, 1'b0, 4'd1);
        stepCycle();
        checkOutput("post-reset no flush_done", 32'(flush_done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
